// File: rtl/clock_divider_ctrl_if.sv
// Config port of the clock divider controller: valid/ready divide-value offer plus error pulse.
// The host drives cfg_valid/cfg_div; the controller answers with cfg_ready/cfg_err.
interface clock_divider_ctrl_if #(
  parameter int unsigned DIV_WIDTH = 24
);
  logic                 cfg_valid;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_ready;
  logic                 cfg_err;

  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clock_divider_ctrl.sv
// Run-time start/stop and divide-value loading for a programmable clock divider.
// out/tick are decoded from flops; new divide values only take effect at period boundaries.
module clock_divider_ctrl #(
  parameter int unsigned DIV_WIDTH   = 24,
  parameter int unsigned DEFAULT_DIV = 12000000,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  clock_divider_ctrl_if.slave  cfg,
  output logic                 out,
  output logic                 tick,
  output logic                 running,
  output logic                 pend,
  output logic [DIV_WIDTH-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] shadow;
  logic                 err_q;
  logic                 xfer;
  logic                 bad_div;

  assign running       = (state != IDLE);
  assign out           = running && (count < (cur_div >> 1));
  assign tick          = running && (count == cur_div - 1'b1);
  assign cfg.cfg_ready = !pend;
  assign cfg.cfg_err   = err_q;
  assign xfer          = cfg.cfg_valid && !pend;
  assign bad_div       = (cfg.cfg_div < DIV_WIDTH'(MIN_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      cur_div <= DIV_WIDTH'(DEFAULT_DIV);
      shadow  <= '0;
      pend    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= xfer && bad_div;

      case (state)
        IDLE: begin
          count <= '0;
          if (start && !stop) state <= RUN;
        end
        RUN: begin
          count <= tick ? '0 : count + 1'b1;
          if (stop) state <= STOPPING;
        end
        STOPPING: begin
          if (tick) begin
            count <= '0;
            state <= IDLE;
          end else begin
            // Restart before the boundary keeps the period running without a gap.
            count <= count + 1'b1;
            if (start && !stop) state <= RUN;
          end
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase

      // pend blocks cfg_ready, so a new transfer and a shadow commit never coincide.
      if (xfer && !bad_div) begin
        if (!running || tick) begin
          cur_div <= cfg.cfg_div;
        end else begin
          shadow <= cfg.cfg_div;
          pend   <= 1'b1;
        end
      end else if (pend && tick) begin
        cur_div <= shadow;
        pend    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench: each row drives one cycle of inputs and queues the outputs expected in that cycle;
// a negedge monitor pops and compares the queue.
module tb_clock_divider_ctrl;

  localparam int unsigned DW  = 24;
  localparam int unsigned DEF = 12000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          out, tick, running, pend;
  logic [DW-1:0] cur_div;

  clock_divider_ctrl_if #(.DIV_WIDTH(DW)) cfg ();

  clock_divider_ctrl #(.DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .MIN_DIV(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .cfg     (cfg),
    .out     (out),
    .tick    (tick),
    .running (running),
    .pend    (pend),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  // flags = {out, tick, running, pend, cfg_ready, cfg_err}
  typedef struct {
    int            cyc;
    string         nm;
    logic [5:0]    flags;
    logic [DW-1:0] cur;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [5:0] got;
    exp_t       e;
    got = {out, tick, running, pend, cfg.cfg_ready, cfg.cfg_err};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.nm, cyc, e.cyc);
      end else if (got !== e.flags || cur_div !== e.cur) begin
        n_bad++;
        $display("FAIL %s: got flags=%b cur_div=%0d, required flags=%b cur_div=%0d",
                 e.nm, got, cur_div, e.flags, e.cur);
      end
    end
  end

  // Queue this cycle's expected outputs, drive this cycle's inputs, advance one clock.
  task automatic row(input string nm, input logic r, input logic st, input logic sp,
                     input logic cv, input logic [DW-1:0] cd,
                     input logic [5:0] fl, input logic [DW-1:0] ecur);
    exp_t e;
    e.cyc   = cyc;
    e.nm    = nm;
    e.flags = fl;
    e.cur   = ecur;
    sb.push_back(e);
    rst           = r;
    start         = st;
    stop          = sp;
    cfg.cfg_valid = cv;
    cfg.cfg_div   = cd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    repeat (2) @(posedge clk);
    #1;
    // 1: load 4 in IDLE, start, 1,1,0,0 with tick at count 3
    row("reset_state",  0, 0, 0, 1, 4, 6'b000010, DEF);
    row("idle_load4",   0, 1, 0, 0, 0, 6'b000010, 4);
    row("d4_c0",        0, 0, 0, 0, 0, 6'b101010, 4);
    row("d4_c1",        0, 0, 0, 0, 0, 6'b101010, 4);
    row("d4_c2",        0, 0, 0, 0, 0, 6'b001010, 4);
    row("d4_c3_tick",   0, 0, 0, 0, 0, 6'b011010, 4);
    row("d4_c0b",       0, 0, 0, 0, 0, 6'b101010, 4);
    // 2: cfg 6 at count 1 goes to shadow, commits at the boundary
    row("d4_c1_cfg6",   0, 0, 0, 1, 6, 6'b101010, 4);
    row("pend_c2",      0, 0, 0, 0, 0, 6'b001100, 4);
    row("pend_c3_tick", 0, 0, 0, 0, 0, 6'b011100, 4);
    row("d6_c0",        0, 0, 0, 0, 0, 6'b101010, 6);
    row("d6_c1",        0, 0, 0, 0, 0, 6'b101010, 6);
    row("d6_c2",        0, 0, 0, 0, 0, 6'b101010, 6);
    row("d6_c3",        0, 0, 0, 0, 0, 6'b001010, 6);
    row("d6_c4",        0, 0, 0, 0, 0, 6'b001010, 6);
    row("d6_c5_tick",   0, 0, 0, 0, 0, 6'b011010, 6);
    // 3: value below MIN_DIV is accepted and discarded with an error pulse
    row("d6_c0_cfg1",   0, 0, 0, 1, 1, 6'b101010, 6);
    row("cfg_err",      0, 0, 0, 0, 0, 6'b101011, 6);
    row("err_clear",    0, 0, 0, 0, 0, 6'b101010, 6);
    // boundary transfer loads directly, no pend
    row("d6_c3b",       0, 0, 0, 0, 0, 6'b001010, 6);
    row("d6_c4b",       0, 0, 0, 0, 0, 6'b001010, 6);
    row("bnd_cfg5",     0, 0, 0, 1, 5, 6'b011010, 6);
    row("d5_c0",        0, 0, 0, 0, 0, 6'b101010, 5);
    // 4: stop at count 1 finishes the period
    row("d5_c1_stop",   0, 0, 1, 0, 0, 6'b101010, 5);
    row("stp_c2",       0, 0, 0, 0, 0, 6'b001010, 5);
    row("stp_c3",       0, 0, 0, 0, 0, 6'b001010, 5);
    row("stp_c4_tick",  0, 0, 0, 0, 0, 6'b011010, 5);
    row("stopped_idle", 0, 1, 0, 0, 0, 6'b000010, 5);
    row("rs_c0",        0, 0, 0, 0, 0, 6'b101010, 5);
    row("rs_c1_stop",   0, 0, 1, 0, 0, 6'b101010, 5);
    row("rs_stp_c2",    0, 0, 0, 0, 0, 6'b001010, 5);
    row("rs_c3_start",  0, 1, 0, 0, 0, 6'b001010, 5);
    row("nogap_c4",     0, 0, 0, 0, 0, 6'b011010, 5);
    // 5: async reset mid-period with a pending value
    row("nogap_c0_cfg", 0, 0, 0, 1, 7, 6'b101010, 5);
    row("pend_c1",      0, 0, 0, 0, 0, 6'b101100, 5);
    row("async_rst",    1, 0, 0, 0, 0, 6'b000010, DEF);
    // 6: start+stop together stays idle; cfg+start together runs with the new value
    row("rst_release",  0, 1, 1, 0, 0, 6'b000010, DEF);
    row("ss_idle",      0, 1, 0, 1, 3, 6'b000010, DEF);
    row("d3_c0",        0, 0, 0, 0, 0, 6'b101010, 3);
    row("d3_c1",        0, 0, 0, 0, 0, 6'b001010, 3);
    row("d3_c2_tick",   0, 0, 0, 0, 0, 6'b011010, 3);
    // MIN_DIV itself is legal
    row("d3_c0_cfg2",   0, 0, 0, 1, 2, 6'b101010, 3);
    row("pend2_c1",     0, 0, 0, 0, 0, 6'b001100, 3);
    row("pend2_c2_tck", 0, 0, 0, 0, 0, 6'b011100, 3);
    row("d2_c0",        0, 0, 0, 0, 0, 6'b101010, 2);
    row("d2_c1_tick",   0, 0, 0, 0, 0, 6'b011010, 2);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
